// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-side and EX-side signal bundle for id_stage
interface id_stage_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        pc;
    logic [15:0]       instr;
    logic              instr_fetch_enable;
    logic              branch_enable;
    logic [5:0]        imm_branch_offset;
    logic              ex_valid;
    logic [3:0]        ex_op;
    logic [2:0]        ex_funct;
    logic [2:0]        ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;

    modport master (
        input  pc, instr,
        output instr_fetch_enable, branch_enable, imm_branch_offset,
        output ex_valid, ex_op, ex_funct, ex_rd, ex_a, ex_b, ex_imm
    );

    modport slave (
        output pc, instr,
        input  instr_fetch_enable, branch_enable, imm_branch_offset,
        input  ex_valid, ex_op, ex_funct, ex_rd, ex_a, ex_b, ex_imm
    );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, hazard bubbles, branch resolve, EX issue
// Optional BNE (opcode 6) enabled by defining ID_BRANCH_NE_EN.
module id_stage #(
    parameter int          DATA_W = 8,
    parameter logic [15:0] NOP    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_if.master        bus,
    output logic [2:0]        rf_raddr1,
    output logic [2:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              id_state
);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_SW   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;

    typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [15:0]       id_instr_q, id_instr_d;
    logic [7:0]        id_pc_q, id_pc_d;
    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [2:0]        ex_funct_q, ex_funct_d;
    logic [2:0]        ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;

    logic [3:0] op;
    logic [2:0] rd, rs, rt, src2;
    logic       is_r, is_branch, use_rs, use_src2;
    logic       rs_hit, src2_hit, ex_writes, hazard, taken;

    always_comb begin
        rd = id_instr_q[11:9];
        rs = id_instr_q[8:6];
        rt = id_instr_q[5:3];

        op = OP_NOP;
        case (id_instr_q[15:12])
            OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ: op = id_instr_q[15:12];
`ifdef ID_BRANCH_NE_EN
            OP_BNE:                                op = OP_BNE;
`endif
            default:                               op = OP_NOP;
        endcase

        is_r      = (op == OP_ALU);
        is_branch = (op == OP_BEQ) || (op == OP_BNE);
        use_rs    = (op != OP_NOP);
        use_src2  = is_r || (op == OP_SW) || is_branch;
        src2      = is_r ? rt : rd;
        rf_raddr1 = rs;
        rf_raddr2 = src2;

        // r0 is hardwired, so a match on it is never a real dependency
        rs_hit    = use_rs && (rs != 3'd0) && (rs == ex_rd_q);
        src2_hit  = use_src2 && (src2 != 3'd0) && (src2 == ex_rd_q);
        ex_writes = ex_valid_q && ((ex_op_q == OP_ALU) || (ex_op_q == OP_ADDI) || (ex_op_q == OP_LW));
        hazard    = (state_q == S_RUN) &&
                    (((ex_valid_q && ex_op_q == OP_LW) && (rs_hit || src2_hit)) ||
                     (is_branch && ex_writes && (rs_hit || src2_hit)));

        // Hazard only fires in RUN, so after the bubble a waiting branch resolves normally
        taken = is_branch && !hazard &&
                ((op == OP_BNE) ? (rf_rdata1 != rf_rdata2) : (rf_rdata1 == rf_rdata2));

        id_instr_d = hazard ? id_instr_q : bus.instr;
        id_pc_d    = hazard ? id_pc_q : bus.pc;
        state_d    = hazard ? S_STALL : S_RUN;

        ex_valid_d = 1'b0;
        ex_op_d    = '0;
        ex_funct_d = '0;
        ex_rd_d    = '0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_imm_d   = '0;
        if (!hazard && op != OP_NOP) begin
            ex_valid_d = 1'b1;
            ex_op_d    = op;
            ex_funct_d = is_r ? id_instr_q[2:0] : 3'd0;
            ex_rd_d    = rd;
            ex_a_d     = rf_rdata1;
            ex_b_d     = use_src2 ? rf_rdata2 : '0;
            ex_imm_d   = {{(DATA_W-6){id_instr_q[5]}}, id_instr_q[5:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_funct_q <= '0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_funct_q <= ex_funct_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
        end
    end

    // Fetch computes the branch target itself, so the latched PC has no consumer here
    logic unused_id_pc;
    assign unused_id_pc = ^id_pc_q;

    assign bus.instr_fetch_enable = !hazard;
    assign bus.branch_enable      = taken;
    assign bus.imm_branch_offset  = id_instr_q[5:0];
    assign bus.ex_valid           = ex_valid_q;
    assign bus.ex_op              = ex_op_q;
    assign bus.ex_funct           = ex_funct_q;
    assign bus.ex_rd              = ex_rd_q;
    assign bus.ex_a               = ex_a_q;
    assign bus.ex_b               = ex_b_q;
    assign bus.ex_imm             = ex_imm_q;
    assign id_state               = state_q;
endmodule
